// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared types and helpers for the four-way round-robin arbiter.
// Holds the state encoding, requester geometry and the rotating-priority search.
package mux4_arb_pkg;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned SEL_W = 2;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] idx;
  } pick_t;

  // First set bit of valid, searching ptr, ptr+1, ... with 2-bit wraparound.
  // The loop runs from the farthest offset down so the nearest candidate wins.
  function automatic pick_t rr_pick(input logic [N_REQ-1:0] valid,
                                    input logic [SEL_W-1:0] ptr);
    pick_t            p;
    logic [SEL_W-1:0] cand;
    p = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      cand = ptr + SEL_W'(i);
      if (valid[cand]) begin
        p.found = 1'b1;
        p.idx   = cand;
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/mux4_rr_arbiter_mux2s.sv
// Parameterised 4:1 select mux; routes the granted requester's payload.
module mux2s #(
  parameter int unsigned w = 8
) (
  input  logic [1:0]   s,
  input  logic [w-1:0] d0,
  input  logic [w-1:0] d1,
  input  logic [w-1:0] d2,
  input  logic [w-1:0] d3,
  output logic [w-1:0] y
);

  always_comb begin
    y = d0;
    unique case (s)
      2'd0: y = d0;
      2'd1: y = d1;
      2'd2: y = d2;
      2'd3: y = d3;
    endcase
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Four-requester round-robin arbiter with optional burst locking, feeding a
// one-entry registered output stage with its own valid/ready handshake.
module mux4_rr_arbiter
  import mux4_arb_pkg::*;
#(
  parameter int unsigned w     = 8,
  parameter int unsigned BURST = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [3:0]   req_valid,
  input  logic [w-1:0] req_data0,
  input  logic [w-1:0] req_data1,
  input  logic [w-1:0] req_data2,
  input  logic [w-1:0] req_data3,
  output logic [3:0]   req_ready,
  output logic         out_valid,
  output logic [w-1:0] out_data,
  output logic [1:0]   out_src,
  input  logic         out_ready
);

  localparam logic [3:0] BurstCnt = 4'(BURST);

  arb_state_e state_q, state_d;
  logic [1:0] owner_q, owner_d;
  logic [1:0] ptr_q, ptr_d;
  logic [3:0] beat_q, beat_d;
  logic       out_valid_q;
  logic [w-1:0] out_data_q;
  logic [1:0] out_src_q;

  logic       load;
  logic       owner_hold;
  logic [1:0] search_ptr;
  pick_t      pick;
  logic [1:0] winner;
  logic       found;
  logic [3:0] beat_inc;
  logic [w-1:0] mux_y;

  // Winner selection. A locked owner that dropped valid releases in this same
  // cycle, so the search restarts just past it and no bubble is inserted.
  always_comb begin
    load       = !out_valid_q || out_ready;
    owner_hold = (state_q == LOCKED) && req_valid[owner_q];
    search_ptr = (state_q == LOCKED) ? owner_q + 2'd1 : ptr_q;
    pick       = rr_pick(req_valid, search_ptr);
    winner     = owner_hold ? owner_q : pick.idx;
    found      = owner_hold || pick.found;
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    ptr_d    = ptr_q;
    beat_d   = beat_q;
    beat_inc = beat_q + 4'd1;
    if (load) begin
      if (owner_hold) begin
        if (beat_inc == BurstCnt) begin
          state_d = IDLE;
          ptr_d   = owner_q + 2'd1;
          beat_d  = 4'd0;
        end else begin
          beat_d = beat_inc;
        end
      end else begin
        state_d = IDLE;
        ptr_d   = search_ptr;
        beat_d  = 4'd0;
        if (pick.found) begin
          if (BURST > 1) begin
            state_d = LOCKED;
            owner_d = pick.idx;
            beat_d  = 4'd1;
          end else begin
            ptr_d = pick.idx + 2'd1;
          end
        end
      end
    end
  end

  always_comb begin
    req_ready = 4'b0000;
    if (rst_n && load && found) begin
      req_ready[winner] = 1'b1;
    end
  end

  mux2s #(
    .w(w)
  ) u_mux (
    .s (winner),
    .d0(req_data0),
    .d1(req_data1),
    .d2(req_data2),
    .d3(req_data3),
    .y (mux_y)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_q     <= 2'd0;
      ptr_q       <= 2'd0;
      beat_q      <= 4'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      beat_q  <= beat_d;
      if (load) begin
        out_valid_q <= found;
        if (found) begin
          out_data_q <= mux_y;
          out_src_q  <= winner;
        end
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter: three instances (BURST 1, 3, 4) run against a
// behavioural round-robin model, with directed scenarios then random traffic.
module tb_mux4_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] rv   [3];
  logic [7:0] rd   [3][4];
  logic       ordy [3];
  logic [3:0] rr   [3];
  logic       ov   [3];
  logic [7:0] od   [3];
  logic [1:0] os   [3];

  int burst_of [3];
  int m_ptr    [3];
  int m_owner  [3];
  int m_cnt    [3];
  logic       m_ov  [3];
  logic [7:0] m_od  [3];
  logic [1:0] m_os  [3];
  logic [3:0] m_acc [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mux4_rr_arbiter #(.w(8), .BURST(1)) u_b1 (
    .clk(clk), .rst_n(rst_n), .req_valid(rv[0]),
    .req_data0(rd[0][0]), .req_data1(rd[0][1]), .req_data2(rd[0][2]), .req_data3(rd[0][3]),
    .req_ready(rr[0]), .out_valid(ov[0]), .out_data(od[0]), .out_src(os[0]),
    .out_ready(ordy[0])
  );

  mux4_rr_arbiter #(.w(8), .BURST(3)) u_b3 (
    .clk(clk), .rst_n(rst_n), .req_valid(rv[1]),
    .req_data0(rd[1][0]), .req_data1(rd[1][1]), .req_data2(rd[1][2]), .req_data3(rd[1][3]),
    .req_ready(rr[1]), .out_valid(ov[1]), .out_data(od[1]), .out_src(os[1]),
    .out_ready(ordy[1])
  );

  mux4_rr_arbiter #(.w(8), .BURST(4)) u_b4 (
    .clk(clk), .rst_n(rst_n), .req_valid(rv[2]),
    .req_data0(rd[2][0]), .req_data1(rd[2][1]), .req_data2(rd[2][2]), .req_data3(rd[2][3]),
    .req_ready(rr[2]), .out_valid(ov[2]), .out_data(od[2]), .out_src(os[2]),
    .out_ready(ordy[2])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: model decides the grant from the spec rules, ready is checked
  // before the edge, registered outputs after it.
  task automatic tick();
    logic [3:0] g;
    int         win;
    int         start;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      g = 4'b0000;
      if (!rst_n) begin
        m_ov[k] = 1'b0; m_od[k] = 8'h00; m_os[k] = 2'd0;
        m_ptr[k] = 0; m_owner[k] = -1; m_cnt[k] = 0;
      end else if (!(m_ov[k] && !ordy[k])) begin
        win   = -1;
        start = m_ptr[k];
        if (m_owner[k] >= 0) begin
          if (rv[k][m_owner[k]]) begin
            win = m_owner[k];
          end else begin
            start      = (m_owner[k] + 1) % 4;
            m_ptr[k]   = start;
            m_owner[k] = -1;
            m_cnt[k]   = 0;
          end
        end
        for (int j = 0; j < 4; j++) begin
          if (win < 0 && rv[k][(start + j) % 4]) win = (start + j) % 4;
        end
        if (win >= 0) begin
          g[win]  = 1'b1;
          m_ov[k] = 1'b1;
          m_od[k] = rd[k][win];
          m_os[k] = 2'(win);
          m_cnt[k]++;
          if (m_cnt[k] >= burst_of[k]) begin
            m_ptr[k]   = (win + 1) % 4;
            m_owner[k] = -1;
            m_cnt[k]   = 0;
          end else begin
            m_owner[k] = win;
          end
        end else begin
          m_ov[k] = 1'b0;
        end
      end
      m_acc[k] = g;
      chk($sformatf("ready_b%0d", burst_of[k]), 32'(rr[k]), 32'(g));
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("out_valid_b%0d", burst_of[k]), 32'(ov[k]), 32'(m_ov[k]));
      chk($sformatf("out_data_b%0d", burst_of[k]), 32'(od[k]), 32'(m_od[k]));
      chk($sformatf("out_src_b%0d", burst_of[k]), 32'(os[k]), 32'(m_os[k]));
    end
  endtask

  initial begin
    burst_of[0] = 1; burst_of[1] = 3; burst_of[2] = 4;
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      rv[k] = 4'b0000; ordy[k] = 1'b1; m_acc[k] = 4'b0000;
      m_ov[k] = 1'b0; m_od[k] = 8'h00; m_os[k] = 2'd0;
      m_ptr[k] = 0; m_owner[k] = -1; m_cnt[k] = 0;
      for (int i = 0; i < 4; i++) rd[k][i] = 8'h00;
    end

    // Reset, then a single request from requester 2
    tick(); tick();
    chk("reset_out_valid", 32'(ov[0]), 32'd0);
    chk("reset_out_src", 32'(os[0]), 32'd0);
    rst_n = 1'b1;
    rv[0] = 4'b0100; rd[0][2] = 8'hA5;
    #1 chk("single_ready", 32'(rr[0]), 32'b0100);
    tick();
    chk("single_valid", 32'(ov[0]), 32'd1);
    chk("single_data", 32'(od[0]), 32'hA5);
    chk("single_src", 32'(os[0]), 32'd2);
    rv[0] = 4'b0000;

    // Round-robin fairness from a fresh pointer, BURST=1
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    rv[0] = 4'b1111;
    for (int i = 0; i < 4; i++) rd[0][i] = 8'(8'h10 + i);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("rr_src%0d", i), 32'(os[0]), 32'(i % 4));
      chk($sformatf("rr_valid%0d", i), 32'(ov[0]), 32'd1);
    end

    // Backpressure holds output and pointer
    rd[0][0] = 8'h3C;
    tick();
    chk("bp_load_data", 32'(od[0]), 32'h3C);
    ordy[0] = 1'b0;
    #1 chk("bp_ready_zero", 32'(rr[0]), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("bp_hold%0d", i), 32'(od[0]), 32'h3C);
    end
    ordy[0] = 1'b1;
    #1 chk("bp_resume_ready", 32'(rr[0]), 32'b0010);
    tick();
    chk("bp_resume_src", 32'(os[0]), 32'd1);
    rv[0] = 4'b0000;

    // Burst lock, BURST=3
    rv[1] = 4'b0011;
    for (int i = 0; i < 4; i++) rd[1][i] = 8'(8'hB0 + i);
    for (int i = 0; i < 7; i++) begin
      tick();
      chk($sformatf("burst_src%0d", i), 32'(os[1]), (i >= 3 && i < 6) ? 32'd1 : 32'd0);
    end

    // Reset mid-burst
    tick();
    rst_n = 1'b0;
    tick();
    chk("midrst_valid", 32'(ov[1]), 32'd0);
    chk("midrst_src", 32'(os[1]), 32'd0);
    rst_n = 1'b1;
    rv[1] = 4'b1111;
    #1 chk("midrst_first_ready", 32'(rr[1]), 32'b0001);
    tick();
    chk("midrst_first_src", 32'(os[1]), 32'd0);
    rv[1] = 4'b0000;

    // Early release, BURST=4: owner 1 drops after 2 beats
    rv[2] = 4'b1010;
    for (int i = 0; i < 4; i++) rd[2][i] = 8'(8'hC0 + i);
    tick(); tick();
    chk("early_owner", 32'(os[2]), 32'd1);
    rv[2] = 4'b1000;
    #1 chk("early_ready", 32'(rr[2]), 32'b1000);
    tick();
    chk("early_src", 32'(os[2]), 32'd3);
    rv[2] = 4'b1001;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("early_tail%0d", i), 32'(os[2]), (i < 3) ? 32'd3 : 32'd0);
    end

    // Random traffic; unaccepted words are held stable
    for (int c = 0; c < 400; c++) begin
      rst_n = ($urandom_range(0, 79) != 0);
      for (int k = 0; k < 3; k++) begin
        ordy[k] = ($urandom_range(0, 3) != 0);
        for (int i = 0; i < 4; i++) begin
          if (!(rv[k][i] && !m_acc[k][i])) begin
            rv[k][i] = ($urandom_range(0, 2) != 0);
            rd[k][i] = 8'($urandom);
          end
        end
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
- Shares one w-bit output channel between four requesters using round-robin arbitration with optional burst locking.
- Each requester has a valid/ready handshake. The winning source's data passes through a 4:1 select mux into a one-entry registered output stage with its own valid/ready handshake.
- Sits in front of any single-consumer resource that the four producers must time-share.

Parameters:
- w, 8, data width of each requester and of the output.
- BURST, 1, maximum consecutive beats granted to one owner before the grant rotates (range 1..15).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- req_valid  input  4  bit i = requester i has a word.
- req_data0..req_data3  input  w each  requester payloads.
- req_ready  output  4  one-hot-or-zero; bit i = word i accepted this cycle.
- out_valid  output  1  output register holds a word.
- out_data  output  w  registered payload.
- out_src  output  2  index of the requester that produced out_data.
- out_ready  input  1  consumer accepts out_data this cycle.

Behaviour:
- Reset: one clock, synchronous, active-low (rst_n sampled at a rising clk edge).
  - While rst_n=0: out_valid=0, out_data=0, out_src=0, ptr=0, beat_cnt=0, state=IDLE.
  - req_ready is forced to 4'b0000 combinationally while rst_n=0.
  - Reset mid-burst or with a word pending discards the word; nothing is replayed.
- load = !out_valid || out_ready. The output stage can take a word this cycle.
- State machine:
  - IDLE: no lock. Winner is the first requester with req_valid set, searching ptr, ptr+1, ... mod 4.
  - LOCKED: owner holds the grant. It wins while req_valid[owner]=1, even if others request.
- Transfer occurs when load=1 and a winner exists.
  - req_ready[winner]=1; all other bits are 0.
  - Next edge: out_data<=req_data[winner], out_src<=winner, out_valid<=1.
  - Latency: accept cycle to out_valid is 1 cycle.
  - Zero-bubble streaming is required: with out_ready held at 1, one word transfers every cycle.
- load=1 with no winner: out_valid<=0 next edge.
- load=0: req_ready=0; out_* hold their values and the arbiter state is frozen.
- Burst counter (beat_cnt, 4 bits) counts beats of the current owner.
  - On a transfer from IDLE with BURST>1: go to LOCKED with owner=winner, beat_cnt=1.
  - On a transfer in LOCKED: beat_cnt+1. If it reaches BURST, release: ptr<=owner+1 mod 4, beat_cnt<=0, go to IDLE.
  - BURST=1: every transfer releases immediately (ptr<=winner+1); LOCKED is never entered.
- Owner drops req_valid in LOCKED while load=1: release in the same cycle (ptr=owner+1, beat_cnt=0).
  - Arbitration of the other requesters proceeds in that same cycle using the new ptr, so no idle cycle is inserted.
- Owner drops req_valid while load=0: no release until load=1.
- ptr wraps 3->0. out_src is 2 bits and wraps naturally.
- A requester asserting valid must hold valid and data stable until its ready bit is set. The bench checks this; the RTL does not enforce it.

Decomposition:
- Package mux4_arb_pkg:
  - state enum: IDLE=1'b0, LOCKED=1'b1.
  - localparam N_REQ=4, SEL_W=2.
  - function rr_pick(valid[3:0], ptr[1:0]) returning found and index.
- Sub-module mux2s (the team's parameterised 4:1 select mux):
  - instantiated with w=w, s=winner, d0..d3=req_data0..3.
  - its output feeds the out_data register.
- Arbitration, counter and output register stay in the top module.

Test Plan:
- Reset then single request: hold rst_n=0 for 2 cycles, then req_valid=4'b0100, req_data2=8'hA5, out_ready=1.
  -> req_ready=4'b0100 in the first cycle after reset.
  -> next cycle out_valid=1, out_data=A5, out_src=2.
- Round-robin fairness: BURST=1, req_valid=4'b1111 held, out_ready=1 for 8 cycles.
  -> out_src sequence is 0,1,2,3,0,1,2,3 with no bubbles.
- Backpressure: out_valid=1, out_data=3C, out_ready=0 for 3 cycles with all requesters valid.
  -> req_ready=0, out_data stays 3C, ptr unchanged.
  -> when out_ready=1, the next source granted is ptr.
- Burst lock: BURST=3, req_valid=4'b0011, out_ready=1.
  -> out_src 0,0,0,1,1,1,0...
  -> after the owner-1 burst the grant rotates back to requester 0.
- Early release: BURST=4; owner 1 drops req_valid after 2 beats while req_valid[3]=1.
  -> requester 3 is granted in the same cycle (no bubble), beat_cnt restarts at 1.
- Reset mid-burst: rst_n=0 during LOCKED with out_valid=1.
  -> next edge out_valid=0, out_src=0, ptr=0.
  -> after release, req_valid=4'b1111 grants requester 0 first.
